rr_arbiter_4: RTL

- Round-robin arbiter that shares one resource among 4 requesters.
- Grant is presented one-hot: decoded from the 2-bit owner index, using the same 2-to-4 mapping as our decoder blocks (id 0 -> 4'b0001 ... id 3 -> 4'b1000).
- Sits between requesting masters and a shared datapath; the owner holds the grant until it releases.

---
 rtl/rr_arbiter_4_if.sv | 20 ++
 rtl/rr_arbiter_4.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between masters and the 4-way round-robin arbiter.
// Signals: req[3:0], done, grant[3:0], grant_id[1:0], busy, timeout.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter; owner holds grant until done/req drop.
// Ports: clk, rst_n (async low), bus (slave: req, done -> grant,
// grant_id, busy, timeout). Macro ARB_TIMEOUT_EN adds forced release
// after MAX_HOLD cycles; otherwise timeout is tied low.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD)
  begin : g_bad_cfg
    $error("rr_arbiter_4: bad MAX_HOLD/CNT_W");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t     state;
  logic [1:0] ptr;

  function automatic logic [3:0] dec(input logic [1:0] id);
    logic [3:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // {hit, id}: first set bit from p upward with wrap.
  // Walks offsets high to low so the smallest offset wins.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] idle_pick;
  logic [2:0] hand_pick;
  logic [1:0] nxt_ptr;
  logic       nrm_rel;
  logic       force_rel;
  logic       rel;

  always_comb begin
    nxt_ptr   = bus.grant_id + 2'd1;
    nrm_rel   = bus.done | ~bus.req[bus.grant_id];
    rel       = nrm_rel | force_rel;
    idle_pick = pick(bus.req, ptr);
    // Outgoing owner masked: it cannot win its own release edge.
    hand_pick = pick(bus.req & ~dec(bus.grant_id), nxt_ptr);
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign force_rel = (state == GRANTED) &&
                     (cnt == CNT_W'(MAX_HOLD - 1)) &&
                     !nrm_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == GRANTED && !rel) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state        <= GRANTED;
            bus.grant_id <= idle_pick[1:0];
            bus.grant    <= dec(idle_pick[1:0]);
            bus.busy     <= 1'b1;
          end
        end
        GRANTED: begin
          if (rel) begin
            ptr         <= nxt_ptr;
            bus.timeout <= force_rel;
            if (hand_pick[2]) begin
              bus.grant_id <= hand_pick[1:0];
              bus.grant    <= dec(hand_pick[1:0]);
            end else begin
              state     <= IDLE;
              bus.grant <= '0;
              bus.busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
